fetch_ctrl: RTL and testbench

Fetch-stage sequencer for the RV32I core. It owns the program counter and decides the next fetch address: sequential PC+4, a branch/jump redirect, or a trap vector. It runs a single-outstanding-request handshake to instruction memory and presents each fetched instruction with its PC to decode through a valid/ready output register. Any response made stale by a redirect is discarded.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_perf_cnt.sv | 38 +++
 rtl/fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch-stage sequencer.
//   fetch_state_e  - sequencer state encoding
//   INSN_BYTES     - byte stride between sequential instructions
//   MISALIGN_MASK  - low PC bits that must be zero for a legal target
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DROP
  } fetch_state_e;

  localparam int unsigned INSN_BYTES    = 4;
  localparam logic [1:0]  MISALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: free-running event counters for the fetch stage.
// Both counters wrap at 2^32.
//   clk_i, rst_i     - clock, synchronous active-high reset
//   fetched_inc_i    - one instruction handed to decode this cycle
//   flushed_inc_i    - one response or held instruction discarded this cycle
//   fetched_o        - running count of fetched instructions
//   flushed_o        - running count of discarded instructions
module fetch_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetched_inc_i,
  input  logic        flushed_inc_i,
  output logic [31:0] fetched_o,
  output logic [31:0] flushed_o
);

  logic [31:0] fetched_q, fetched_d;
  logic [31:0] flushed_q, flushed_d;

  always_comb begin
    fetched_d = fetched_q + {31'd0, fetched_inc_i};
    flushed_d = flushed_q + {31'd0, flushed_inc_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end

  assign fetched_o = fetched_q;
  assign flushed_o = flushed_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: RV32I fetch-stage sequencer. Owns the PC, issues one
// outstanding instruction-memory request at a time and presents each
// fetched word with its PC to decode through a valid/ready register.
// Responses made stale by a trap or redirect are discarded.
// Optional feature macro: FETCH_CTRL_PERF_EN (builds the perf counters;
// otherwise o_perf_fetched/o_perf_flushed are tied to zero).
//   i_clk, i_rst                      - clock, synchronous active-high reset
//   i_redirect_valid/i_redirect_addr  - branch/jump redirect from execute
//   i_trap_valid                      - trap request, wins over redirect
//   o_mem_req/o_mem_addr/i_mem_ready  - request channel (addr = PC)
//   i_mem_rvalid/i_mem_rdata          - response channel
//   o_inst_valid/o_inst/o_inst_pc     - instruction to decode
//   i_inst_ready                      - decode accept
//   o_misaligned                      - pulse: redirect target misaligned
//   o_perf_fetched/o_perf_flushed     - performance counters
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC   = 32'h0000_0004
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_addr,
  input  logic        i_trap_valid,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  output logic        o_misaligned,
  output logic [31:0] o_perf_fetched,
  output logic [31:0] o_perf_flushed
);

  localparam logic [31:0] INSN_STEP = 32'(INSN_BYTES);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         inst_valid_q, inst_valid_d;
  logic         misaligned_q, misaligned_d;

  logic         flush;
  logic         redir_misaligned;
  logic         mem_accept;
  logic [31:0]  flush_pc;

  assign flush            = i_trap_valid | i_redirect_valid;
  // A misaligned target only matters when the redirect is the winner.
  assign redir_misaligned = i_redirect_valid & ~i_trap_valid &
                            ((i_redirect_addr[1:0] & MISALIGN_MASK) != '0);
  assign flush_pc         = (i_trap_valid | redir_misaligned) ? TRAP_VEC : i_redirect_addr;
  assign mem_accept       = (state_q == ST_REQ) & i_mem_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    misaligned_d = redir_misaligned;

    // A trap/redirect retargets the PC in every state; the state-specific
    // part below only decides what happens to in-flight work.
    if (flush) pc_d = flush_pc;

    case (state_q)
      ST_RST: state_d = ST_REQ;
      ST_REQ: begin
        if (mem_accept) state_d = flush ? ST_DROP : ST_WAIT;
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = i_mem_rvalid ? ST_REQ : ST_DROP;
        end else if (i_mem_rvalid) begin
          inst_d       = i_mem_rdata;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + INSN_STEP;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // A flush kills the held instruction even if decode accepts it now.
        if (flush || i_inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = ST_REQ;
        end
      end
      ST_DROP: begin
        if (i_mem_rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_RST;
      pc_q         <= RESET_ADDR;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign o_mem_req    = (state_q == ST_REQ);
  assign o_mem_addr   = pc_q;
  assign o_inst_valid = inst_valid_q;
  assign o_inst       = inst_q;
  assign o_inst_pc    = inst_pc_q;
  assign o_misaligned = misaligned_q;

`ifdef FETCH_CTRL_PERF_EN
  logic fetched_inc;
  logic flushed_inc;

  assign fetched_inc = (state_q == ST_HOLD) & i_inst_ready & ~flush;
  assign flushed_inc = ((state_q == ST_HOLD) & flush) |
                       ((state_q == ST_WAIT) & flush & i_mem_rvalid) |
                       ((state_q == ST_DROP) & i_mem_rvalid);

  fetch_perf_cnt u_perf (
    .clk_i         (i_clk),
    .rst_i         (i_rst),
    .fetched_inc_i (fetched_inc),
    .flushed_inc_i (flushed_inc),
    .fetched_o     (o_perf_fetched),
    .flushed_o     (o_perf_flushed)
  );
`else
  assign o_perf_fetched = '0;
  assign o_perf_flushed = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl. A transaction-level
// reference (expected next fetch address, one in-flight slot, live flag)
// predicts request addresses, delivered instructions and counter totals.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC   = 32'h0000_0004;
`ifdef FETCH_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_addr;
  logic        i_trap_valid;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ready;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready;
  logic        o_misaligned;
  logic [31:0] o_perf_fetched;
  logic [31:0] o_perf_flushed;

  fetch_ctrl #(
    .RESET_ADDR (RESET_ADDR),
    .TRAP_VEC   (TRAP_VEC)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_addr  (i_redirect_addr),
    .i_trap_valid     (i_trap_valid),
    .o_mem_req        (o_mem_req),
    .o_mem_addr       (o_mem_addr),
    .i_mem_ready      (i_mem_ready),
    .i_mem_rvalid     (i_mem_rvalid),
    .i_mem_rdata      (i_mem_rdata),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .i_inst_ready     (i_inst_ready),
    .o_misaligned     (o_misaligned),
    .o_perf_fetched   (o_perf_fetched),
    .o_perf_flushed   (o_perf_flushed)
  );

  always #5 i_clk = ~i_clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference state
  bit          slot_busy;
  int unsigned slot_delay;
  logic [31:0] slot_addr;
  bit          live;
  logic [31:0] live_addr;
  logic [31:0] exp_addr;
  bit          exp_mis;
  int unsigned n_hs, n_killed, cyc;
  bit          mem_rand;
  int unsigned mem_lat;
  logic [31:0] acc_addr[$];
  int unsigned acc_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] exp_perf(input logic [31:0] n);
    return PERF ? n : 32'd0;
  endfunction

  function automatic logic [31:0] rand_target();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'hFFFF_FFFC;
    if (k == 1) return 32'hFFFF_FFF8;
    if (k == 2) return (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
    return 32'($urandom_range(0, 255)) << 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit mready, input bit iready, input bit redir,
                      input logic [31:0] raddr, input bit trap);
    bit acc, hs, fl, rv;
    rv = slot_busy && (slot_delay == 0);
    i_mem_rvalid     = rv;
    i_mem_rdata      = rv ? mem_word(slot_addr) : $urandom;
    i_mem_ready      = mready;
    i_inst_ready     = iready;
    i_redirect_valid = redir;
    i_redirect_addr  = raddr;
    i_trap_valid     = trap;

    chk("misaligned_pulse", {31'd0, o_misaligned}, {31'd0, exp_mis});
    if (o_inst_valid) chk("valid_without_live_fetch", {31'd0, live}, 32'd1);

    acc = o_mem_req && mready;
    hs  = o_inst_valid && iready;
    fl  = redir || trap;

    if (acc) begin
      chk("req_addr", o_mem_addr, exp_addr);
      chk("single_outstanding", {31'd0, slot_busy}, 32'd0);
      acc_addr.push_back(o_mem_addr);
      acc_cyc.push_back(cyc);
    end
    if (hs && !fl) begin
      chk("inst_pc", o_inst_pc, live_addr);
      chk("inst_word", o_inst, mem_word(live_addr));
      live = 1'b0;
      n_hs++;
    end

    if (rv) slot_busy = 1'b0;
    else if (slot_busy) slot_delay--;
    if (acc) begin
      slot_busy  = 1'b1;
      slot_addr  = o_mem_addr;
      slot_delay = mem_rand ? $urandom_range(0, 3) : mem_lat;
    end

    if (fl && (live || acc)) n_killed++;
    if (acc && !fl) begin
      live      = 1'b1;
      live_addr = o_mem_addr;
      exp_addr  = o_mem_addr + 32'd4;
    end
    if (fl) begin
      live     = 1'b0;
      exp_addr = (trap || raddr[1:0] != 2'b00) ? TRAP_VEC : raddr;
    end
    exp_mis = redir && !trap && (raddr[1:0] != 2'b00);
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic do_reset(input int unsigned n);
    i_rst = 1'b1;
    i_redirect_valid = 1'b0; i_redirect_addr = '0; i_trap_valid = 1'b0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0; i_inst_ready = 1'b0;
    repeat (n) @(negedge i_clk);
    chk("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
    chk("rst_mem_addr", o_mem_addr, RESET_ADDR);
    chk("rst_inst_valid", {31'd0, o_inst_valid}, 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_inst_pc", o_inst_pc, 32'd0);
    chk("rst_misaligned", {31'd0, o_misaligned}, 32'd0);
    chk("rst_perf_fetched", o_perf_fetched, 32'd0);
    chk("rst_perf_flushed", o_perf_flushed, 32'd0);
    slot_busy = 1'b0; slot_delay = 0; live = 1'b0; exp_addr = RESET_ADDR;
    exp_mis = 1'b0; n_hs = 0; n_killed = 0;
    i_rst = 1'b0;
    // First cycle out of reset is still RST: no request yet.
    chk("rst_cycle_no_req", {31'd0, o_mem_req}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("first_req", {31'd0, o_mem_req}, 32'd1);
    chk("first_req_addr", o_mem_addr, RESET_ADDR);
  endtask

  initial begin
    bit          ok, seen_valid;
    int unsigned a0;
    logic [31:0] held_inst, held_pc;

    cyc = 0; mem_rand = 1'b0; mem_lat = 0;
    @(negedge i_clk);
    do_reset(3);

    // Zero-wait memory, decode always ready: 0x0, 0x4, 0x8 every 3 cycles.
    acc_addr.delete(); acc_cyc.delete();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      ok = (acc_addr.size() >= 3);
    end
    chk("seq_timeout", {31'd0, ok}, 32'd1);
    if (ok) begin
      chk("seq_addr0", acc_addr[0], 32'h0);
      chk("seq_addr1", acc_addr[1], 32'h4);
      chk("seq_addr2", acc_addr[2], 32'h8);
      chk("seq_spacing01", acc_cyc[1] - acc_cyc[0], 32'd3);
      chk("seq_spacing12", acc_cyc[2] - acc_cyc[1], 32'd3);
    end

    // Redirect to 0x100 while WAIT has no response yet.
    mem_lat = 2;
    a0 = acc_addr.size(); ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      ok = (acc_addr.size() > a0);
    end
    chk("wait_entry_timeout", {31'd0, ok}, 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
    a0 = acc_addr.size(); ok = 1'b0; seen_valid = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      seen_valid |= o_inst_valid;
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      ok = (acc_addr.size() > a0);
    end
    chk("redir_timeout", {31'd0, ok}, 32'd1);
    chk("redir_no_valid", {31'd0, seen_valid}, 32'd0);
    if (ok) chk("redir_addr", acc_addr[a0], 32'h100);
    chk("redir_perf_fetched", o_perf_fetched, exp_perf(32'd3));
    chk("redir_perf_flushed", o_perf_flushed, exp_perf(32'd1));

    // Trap and redirect together while holding an instruction.
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      ok = o_inst_valid;
    end
    chk("hold_entry_timeout", {31'd0, ok}, 32'd1);
    mem_lat = 0;
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
    chk("trap_prio_req", {31'd0, o_mem_req}, 32'd1);
    chk("trap_prio_addr", o_mem_addr, TRAP_VEC);
    chk("trap_flush_valid", {31'd0, o_inst_valid}, 32'd0);

    // Redirects while a request is pending but not accepted.
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    chk("req_retarget_addr", o_mem_addr, 32'h40);
    step(1'b0, 1'b0, 1'b1, 32'h102, 1'b0);
    chk("misaligned_set", {31'd0, o_misaligned}, 32'd1);
    chk("misaligned_addr", o_mem_addr, TRAP_VEC);
    chk("misaligned_req", {31'd0, o_mem_req}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("misaligned_clear", {31'd0, o_misaligned}, 32'd0);

    // PC wrap from 0xFFFFFFFC.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("wrap_start_addr", o_mem_addr, 32'hFFFF_FFFC);
    a0 = acc_addr.size(); ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      ok = (acc_addr.size() >= a0 + 2);
    end
    chk("wrap_timeout", {31'd0, ok}, 32'd1);
    if (ok) begin
      chk("wrap_first", acc_addr[a0], 32'hFFFF_FFFC);
      chk("wrap_next", acc_addr[a0+1], 32'h0);
    end

    // Decode stalls for 5 cycles.
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      ok = o_inst_valid;
    end
    chk("stall_entry_timeout", {31'd0, ok}, 32'd1);
    held_inst = mem_word(live_addr);
    held_pc   = live_addr;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("stall_inst", o_inst, held_inst);
      chk("stall_pc", o_inst_pc, held_pc);
      chk("stall_no_req", {31'd0, o_mem_req}, 32'd0);
    end
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("stall_release_req", {31'd0, o_mem_req}, 32'd1);
    chk("stall_release_valid", {31'd0, o_inst_valid}, 32'd0);

    // Randomized traffic against the reference.
    mem_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit rd, tr;
      rd = ($urandom_range(0, 9) == 0);
      tr = ($urandom_range(0, 24) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rd, rand_target(), tr);
    end
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      ok = !slot_busy && !live;
    end
    chk("drain_timeout", {31'd0, ok}, 32'd1);
    chk("rand_progress", {31'd0, n_hs > 200}, 32'd1);
    chk("rand_perf_fetched", o_perf_fetched, exp_perf(n_hs));
    chk("rand_perf_flushed", o_perf_flushed, exp_perf(n_killed));

    // Reset in the middle of a transaction.
    mem_rand = 1'b0; mem_lat = 2;
    a0 = acc_addr.size(); ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      ok = (acc_addr.size() > a0);
    end
    chk("midrst_entry_timeout", {31'd0, ok}, 32'd1);
    do_reset(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
